// File: rtl/aggregate.sv
// Packs the firewall's 2-bit dibit stream into 32-bit words, tags the last whole
// word of each packet and buffers the words in a small FIFO behind valid/ready.
module aggregate #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    input  logic        axior,
    output logic        axiov,
    output logic [31:0] axiod,
    output logic        axiolast,
    output logic        overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [29:0]   r_sr;
    logic [3:0]    r_cnt;
    logic          r_prev_v;
    logic          r_pend_v;
    logic [31:0]   r_pend_d;
    logic [32:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_pkt_end;
    logic          w_complete;
    logic [31:0]   w_word;
    logic          w_push;
    logic [32:0]   w_push_d;
    logic          w_full;
    logic          w_pop;
    logic          w_accept;

    assign w_pkt_end  = !axiiv && r_prev_v;
    assign w_complete = axiiv && (r_cnt == 4'd15);
    assign w_word     = {r_sr, axiid};

    // A pending word is only known to be "last" once the packet ends, so it
    // waits here until either the next word completes or the packet closes.
    assign w_push   = r_pend_v && (w_complete || w_pkt_end);
    assign w_push_d = {w_pkt_end, r_pend_d};

    assign w_full   = (r_count == FULL_CNT);
    assign axiov    = (r_count != '0);
    assign w_pop    = axiov && axior;
    assign w_accept = w_push && (!w_full || w_pop);

    // NOTE: the storage array has no reset; the head is masked while empty so
    // the outputs still read zero after reset.
    assign {axiolast, axiod} = axiov ? r_mem[r_rd_ptr] : 33'd0;
    assign overflow = r_overflow;

    // NOTE: all state below updates with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr     <= '0;
            r_cnt    <= '0;
            r_prev_v <= 1'b0;
            r_pend_v <= 1'b0;
            r_pend_d <= '0;
        end else begin
            r_prev_v <= axiiv;
            if (axiiv) begin
                r_sr  <= {r_sr[27:0], axiid};
                r_cnt <= r_cnt + 4'd1;
            end else if (w_pkt_end) begin
                r_sr  <= '0;
                r_cnt <= '0;
            end
            if (w_complete) begin
                r_pend_d <= w_word;
                r_pend_v <= 1'b1;
            end else if (w_pkt_end) begin
                r_pend_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_push_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Sticky: a full FIFO with nothing leaving drops the committed word.
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aggregate.sv
// Directed bench for aggregate: hand-computed words, last flags, overflow,
// reset mid-packet and stall behaviour, sampled 1 time unit after each edge.
module tb_aggregate;

    logic        clk = 1'b0;
    logic        rst;
    logic        axiiv;
    logic [1:0]  axiid;
    logic        axior;
    logic        axiov;
    logic [31:0] axiod;
    logic        axiolast;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    logic [31:0] wds [6];
    logic [31:0] word_f;

    aggregate #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .axiiv    (axiiv),
        .axiid    (axiid),
        .axior    (axior),
        .axiov    (axiov),
        .axiod    (axiod),
        .axiolast (axiolast),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] d);
        axiiv = 1'b1;
        axiid = d;
        tick();
    endtask

    task automatic idle(input int n);
        axiiv = 1'b0;
        axiid = 2'd0;
        repeat (n) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int j = 0; j < n; j++) begin
            send(w[31-2*j -: 2]);
        end
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic last);
        check({tag, " valid"}, {32'd0, axiov}, 33'd1);
        check({tag, " word"}, {axiolast, axiod}, {last, d});
    endtask

    task automatic expect_empty(input string tag);
        check({tag, " empty"}, {32'd0, axiov}, 33'd0);
    endtask

    initial begin
        wds[0] = 32'h0123_4567;
        wds[1] = 32'h89AB_CDEF;
        wds[2] = 32'hDEAD_BEEF;
        wds[3] = 32'hCAFE_F00D;
        wds[4] = 32'h1111_2222;
        wds[5] = 32'h3333_4444;
        word_f = 32'h5A5A_F00F;

        rst   = 1'b1;
        axiiv = 1'b0;
        axiid = 2'd0;
        axior = 1'b0;
        repeat (2) tick();
        check("reset axiov", {32'd0, axiov}, 33'd0);
        check("reset head", {axiolast, axiod}, 33'd0);
        check("reset overflow", {32'd0, overflow}, 33'd0);
        rst = 1'b0;
        idle(2);

        // All-ones packet, 32 dibits.
        axior = 1'b1;
        for (int i = 0; i < 31; i++) send(2'b11);
        expect_empty("ones before 32nd");
        send(2'b11);
        expect_word("ones w0", 32'hFFFF_FFFF, 1'b0);
        idle(1);
        expect_word("ones w1", 32'hFFFF_FFFF, 1'b1);
        idle(1);
        expect_empty("ones drained");

        // 40 dibits of i%3: two words, 8-dibit tail dropped.
        for (int i = 0; i < 32; i++) send(2'(i % 3));
        expect_word("pat w0", 32'h1861_8618, 1'b0);
        for (int i = 32; i < 40; i++) send(2'(i % 3));
        expect_empty("pat tail");
        idle(1);
        expect_word("pat w1", 32'h6186_1861, 1'b1);
        idle(1);
        expect_empty("pat drained");
        check("pat overflow", {32'd0, overflow}, 33'd0);

        // Short packet leaves no trace; the next packet starts at cnt 0.
        for (int i = 0; i < 10; i++) send(2'b11);
        idle(3);
        expect_empty("short");
        for (int i = 0; i < 16; i++) send(2'b01);
        expect_empty("short next pending");
        idle(1);
        expect_word("short next", 32'h5555_5555, 1'b1);
        idle(1);
        expect_empty("short next drained");

        // Six words with no ready: four held, two dropped.
        axior = 1'b0;
        for (int k = 0; k < 6; k++) send_word(wds[k], 16);
        idle(1);
        expect_word("ovf head0", wds[0], 1'b0);
        check("ovf flag", {32'd0, overflow}, 33'd1);
        idle(3);
        expect_word("ovf head0 held", wds[0], 1'b0);
        axior = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            expect_word($sformatf("ovf drain%0d", k), wds[k], 1'b0);
        end
        tick();
        expect_empty("ovf drained");
        check("ovf sticky", {32'd0, overflow}, 33'd1);

        // Reset for one cycle after 20 of 48 dibits (dibit value i%4).
        for (int i = 0; i < 20; i++) send(2'(i % 4));
        rst = 1'b1;
        send(2'(20 % 4));
        check("midrst axiov", {32'd0, axiov}, 33'd0);
        check("midrst head", {axiolast, axiod}, 33'd0);
        check("midrst overflow", {32'd0, overflow}, 33'd0);
        rst = 1'b0;
        for (int i = 21; i < 48; i++) send(2'(i % 4));
        expect_empty("midrst pending");
        idle(1);
        expect_word("midrst word", 32'h6C6C_6C6C, 1'b1);
        idle(1);
        expect_empty("midrst drained");

        // Full FIFO with ready high on commit edges: nothing dropped.
        axior = 1'b0;
        for (int k = 0; k < 5; k++) send_word(wds[k], 16);
        send_word(word_f, 15);
        expect_word("simul head A", wds[0], 1'b0);
        axior = 1'b1;
        send(word_f[1:0]);
        expect_word("simul head B", wds[1], 1'b0);
        idle(1);
        expect_word("simul head C", wds[2], 1'b0);
        tick();
        expect_word("simul head D", wds[3], 1'b0);
        tick();
        expect_word("simul head E", wds[4], 1'b0);
        tick();
        expect_word("simul head F", word_f, 1'b1);
        tick();
        expect_empty("simul drained");
        check("simul overflow", {32'd0, overflow}, 33'd0);

        // Stall: head must hold while ready is low.
        axior = 1'b0;
        send_word(32'hA55A_3CC3, 16);
        idle(1);
        expect_word("stall valid", 32'hA55A_3CC3, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            expect_word($sformatf("stall hold%0d", c), 32'hA55A_3CC3, 1'b1);
        end
        axior = 1'b1;
        tick();
        expect_empty("stall popped");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aggregate.md
# aggregate

Packs the 2-bit dibit stream leaving the firewall into 32-bit words and buffers them in a 4-entry FIFO behind a valid/ready output. It sits directly downstream of `firewall` and upstream of the word consumers (checksum / display path). The block also marks the final whole word of each packet. Any trailing dibits that do not fill a whole word are discarded.

## Interface
- `DEPTH`, 4: FIFO entries. Must be a power of two, ≥2.
- `clk` in 1: system clock. All logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high. It clears all state.
- `axiiv` in 1: input dibit valid. A packet is a contiguous run of `axiiv`=1 cycles.
- `axiid` in 2: input dibit. Packed MSB-first.
- `axior` in 1: downstream ready.
- `axiov` out 1: output word valid. High whenever the FIFO is not empty.
- `axiod` out 32: output word at the FIFO head.
- `axiolast` out 1: the head word is the last whole word of its packet.
- `overflow` out 1: sticky. Set when a committed word is dropped because the FIFO is full.

## Operation
- **Packing.** Shift register `sr <= {sr[29:0], axiid}` on each cycle with `axiiv`=1.
  - A 4-bit dibit counter `cnt` increments on the same cycles and wraps 15→0.
  - The first dibit of a word ends up in `[31:30]`, the 16th in `[1:0]`.
- **Completion.** A word completes on the edge that samples a dibit while `cnt`=15.
  - The completed word `{sr[29:0], axiid}` is held in a pending register, `pend_v`=1.
- **Commit.** The pending word is pushed to the FIFO at exactly one of two events:
  - another word completes while `pend_v`=1: push the old pending word with last=0, and the new word becomes pending in the same edge;
  - packet end (see below) with `pend_v`=1: push with last=1, then `pend_v`<=0.
- **Packet end.** The first edge with `axiiv`=0 while the previous sampled `axiiv` was 1.
  - At packet end, `cnt` and `sr` are cleared. Partial dibits (`cnt`≠0) are discarded without any flag.
  - A packet shorter than 16 dibits produces no output.
- **FIFO.** Holds `DEPTH` entries of 33 bits (data plus last), with wrap-around read/write pointers and an occupancy count 0..`DEPTH`.
  - Pop: an edge where `axiov`=1 and `axior`=1.
  - Push while full with no pop in the same edge: the word is dropped, `overflow`<=1, and the FIFO is unchanged.
  - Push while full with a pop in the same edge: accepted, and occupancy stays at `DEPTH`.
  - Push while empty: there is no fall-through. The word appears at the output one edge later.
  - `axiod`/`axiolast` are don't-care when `axiov`=0 and are held stable while `axiov`=1 and `axior`=0.
- **Input side.** There is no backpressure. The input is never stalled and the block has no input-ready signal.
- **Reset values.** `axiov`=0, `axiod`=0, `axiolast`=0, `overflow`=0, `cnt`=0, `pend_v`=0, and the FIFO is empty.
  - `overflow` clears only on `rst`.
- **Reset mid-packet.** All in-flight state is lost. If `axiiv` is still 1 after `rst` falls, the remaining dibits are treated as a new packet starting at `cnt`=0.

## Timing
- **Mid-packet word k.** Its 16th dibit is sampled at edge E. It is committed at the edge that samples the 16th dibit of word k+1 (E+16 for back-to-back input). `axiov` for it rises after that edge.
- **Last word.** Committed at the packet-end edge P, i.e. the first cycle with `axiiv`=0. `axiov` with `axiolast`=1 is visible in the cycle after P.
- **Throughput.** At most one push per 16 input cycles and one pop per cycle.
- **Idle input.** Cycles with `axiiv`=0 outside a packet have no effect.

## Test plan
- **All-ones packet.** 32 dibits of 2'b11, `axior`=1.
  - Expect two words 0xFFFFFFFF: the first with `axiolast`=0, the second with `axiolast`=1.
  - The first word's `axiov` rises one cycle after the 32nd dibit edge. The second word's `axiov` rises in the cycle after the first `axiiv`=0 edge.
- **Patterned packet with tail.** 40 dibits with `axiid`=i%3, `axior`=1.
  - Expect first word 0x18618618 with last=0, then second word 0x61861861 with last=1.
  - The 8 tail dibits are dropped, and `overflow` stays 0.
- **Short packet.** 10 dibits, then idle.
  - Expect `axiov` to stay 0 throughout. A following 16-dibit packet of 2'b01 must yield 0x55555555 with last=1, proving `cnt` was cleared.
- **Overflow and simultaneous pop.** `axior`=0 with a 96-dibit packet (6 words).
  - Expect 4 entries held and `overflow`=1.
  - Then raise `axior`: the 4 head words drain in order, and the dropped words never appear.
  - With `axior` held 1 while full and a commit arriving on the same edge, confirm no drop.
- **Reset mid-packet.** Pulse `rst` for one cycle after 20 dibits of a 48-dibit packet.
  - Expect all outputs 0 the cycle after `rst`.
  - The remaining 27 dibits produce exactly one word, with last=1, built from dibits 22–37 of the original packet.
- **Stall stability.** After a word is valid, hold `axior`=0 for 5 cycles.
  - Expect `axiod`/`axiolast` constant, then the word pops on the first `axior`=1 edge.
